// File: rtl/qnet_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qnet_dbg_pkg
// Purpose  : Shared debug types for the qnet trace recorders. Holds the trace
//            FSM state type, the reserved EMPTY state code, the qnet command
//            FSM state type, and the command-state to 6-bit code mapping.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package qnet_dbg_pkg;

  // Trace recorder states, as exported on trace_st_o.
  typedef enum logic [1:0] {
    TR_RUN    = 2'd0,
    TR_ARMED  = 2'd1,
    TR_POST   = 2'd2,
    TR_FROZEN = 2'd3
  } TYPE_TRACE_ST;

  // Reserved "no entry" code for the default 6-bit code width.
  localparam logic [5:0] c_qnet_st_empty = 6'd62;

  // qnet command FSM states. 62 is skipped on purpose because it is the
  // EMPTY marker in the trace buffer.
  typedef enum logic [5:0] {
    NOT_READY        = 6'd0,
    READY,
    NET_SET_NODE,
    NET_GET_NODE,
    NET_SET_NET,
    NET_GET_NET,
    NET_SET_TIME,
    NET_GET_TIME,
    NET_SYNC1,
    NET_SYNC2,
    NET_SYNC3,
    NET_SYNC4,
    NET_GET_OFF,
    NET_UPDT_OFF,
    NET_SET_DT,
    NET_GET_DT,
    NET_RST_TMR,
    NET_START_TMR,
    NET_GET_DT_P     = 6'd18,
    NET_RST_PROC_P   = 6'd19,
    NET_START_CORE_P = 6'd20,
    NET_STOP_CORE_P,
    NET_SET_COND_P,
    NET_CLR_COND_P,
    NET_GET_COND_P,
    NET_CUSTOM1_P,
    NET_CUSTOM2_P,
    LOC_SET_DT,
    LOC_GET_DT,
    LOC_START,
    LOC_STOP,
    SEND_CMD,
    WAIT_CMD_ACK,
    SEND_ACK,
    WAIT_CMD,
    WAIT_CMD_nACK    = 6'd35,
    ST_ERROR         = 6'd63
  } TYPE_QNET_CMD;

  // The enum encoding is the trace code, so the mapping is one-to-one.
  function automatic logic [5:0] qnet_cmd_code(input TYPE_QNET_CMD cmd);
    return 6'(cmd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qnet_trace_mem.sv
`default_nettype none
// ============================================================================
// Module   : qnet_trace_mem
// Purpose  : DEPTH x (ST_W + DW_W) circular register file for the state
//            trace. One write port, one registered read port, and an
//            asynchronous HIST_N-entry packed code view walking backwards
//            from a base index.
// Ports    : i_clk, i_rst_n (async, active-low), i_clr (sync clear),
//            i_we/i_wa/i_wcode/i_wdw write port,
//            i_ra -> o_rd_code/o_rd_dw (1-cycle latency),
//            i_hist_base -> o_hist (combinational, base entry in MSBs)
// Revision : 1.0 - initial release
// ============================================================================
module qnet_trace_mem #(
  parameter int              ST_W   = 6,
  parameter int              DW_W   = 16,
  parameter int              DEPTH  = 16,
  parameter int              HIST_N = 5,
  parameter logic [ST_W-1:0] EMPTY  = '1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_wa,
  input  logic [ST_W-1:0]            i_wcode,
  input  logic [DW_W-1:0]            i_wdw,
  input  logic [$clog2(DEPTH)-1:0]   i_ra,
  input  logic [$clog2(DEPTH)-1:0]   i_hist_base,
  output logic [ST_W-1:0]            o_rd_code,
  output logic [DW_W-1:0]            o_rd_dw,
  output logic [ST_W*HIST_N-1:0]     o_hist
);

  localparam int AW = $clog2(DEPTH);

  logic [ST_W-1:0] w_code [DEPTH];
  logic [DW_W-1:0] w_dw   [DEPTH];

  // One register per entry so each can carry its own reset code:
  // entry 0 holds code 0 (the FSM's reset state), the rest are EMPTY.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam logic [ST_W-1:0] c_rst_code = (g == 0) ? '0 : EMPTY;
    logic [ST_W-1:0] r_code;
    logic [DW_W-1:0] r_dw;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_code <= c_rst_code;
        r_dw   <= '0;
      end else if (i_clr) begin
        r_code <= c_rst_code;
        r_dw   <= '0;
      end else if (i_we && (i_wa == AW'(g))) begin
        r_code <= i_wcode;
        r_dw   <= i_wdw;
      end
    end

    assign w_code[g] = r_code;
    assign w_dw[g]   = r_dw;
  end

  // Registered read sees pre-write contents on a same-cycle write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_code <= '0;
      o_rd_dw   <= '0;
    end else begin
      o_rd_code <= w_code[i_ra];
      o_rd_dw   <= w_dw[i_ra];
    end
  end

  for (genvar k = 0; k < HIST_N; k++) begin : g_hist
    assign o_hist[(HIST_N-1-k)*ST_W +: ST_W] = w_code[i_hist_base - AW'(k)];
  end

endmodule
`default_nettype wire

// File: rtl/qnet_st_trace.sv
`default_nettype none
// ============================================================================
// Module   : qnet_st_trace
// Purpose  : State-transition trace recorder for qnet FSMs. Every change of
//            state (cur != nxt) is logged as {code, dwell} in a circular
//            history, with a trigger-armed freeze after a programmable number
//            of post-trigger entries and random-access readout.
// Ports    : st_clk_i, st_rst_ni (async, active-low)
//            cur_st_i/nxt_st_i   monitored FSM state codes
//            clr_i               clear trace, back to RUN
//            arm_i/trig_code_i/post_i  trigger control
//            rd_idx_i -> rd_code_o/rd_dw_o (registered, 0 = newest)
//            hist_o              last HIST_N codes, newest in MSBs
//            trace_st_o, cnt_o, ovf_o  status
// Revision : 1.0 - initial release
// ============================================================================
module qnet_st_trace
  import qnet_dbg_pkg::*;
#(
  parameter int ST_W   = 6,
  parameter int DEPTH  = 16,
  parameter int HIST_N = 5,
  parameter int DW_W   = 16
) (
  input  logic                       st_clk_i,
  input  logic                       st_rst_ni,
  input  logic [ST_W-1:0]            cur_st_i,
  input  logic [ST_W-1:0]            nxt_st_i,
  input  logic                       clr_i,
  input  logic                       arm_i,
  input  logic [ST_W-1:0]            trig_code_i,
  input  logic [$clog2(DEPTH)-1:0]   post_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic [ST_W-1:0]            rd_code_o,
  output logic [DW_W-1:0]            rd_dw_o,
  output logic [ST_W*HIST_N-1:0]     hist_o,
  output logic [1:0]                 trace_st_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       ovf_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [ST_W-1:0] c_empty = ST_W'((1 << ST_W) - 2);
  localparam logic [AW:0]     c_depth = (AW+1)'(DEPTH);

  TYPE_TRACE_ST    r_st, w_st_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_pcnt, w_pcnt_nxt;
  logic [AW:0]     r_cnt;
  logic            r_ovf;
  logic [DW_W-1:0] r_dw_cnt;

  logic            w_chg, w_we, w_trig;
  logic [DW_W-1:0] w_dwell;
  logic [AW-1:0]   w_rd_addr, w_hist_base;

  assign w_chg   = (cur_st_i != nxt_st_i);
  assign w_we    = w_chg && (r_st != TR_FROZEN) && !clr_i;
  assign w_trig  = (nxt_st_i == trig_code_i);
  assign w_dwell = (&r_dw_cnt) ? r_dw_cnt : r_dw_cnt + 1'b1;

  assign w_rd_addr = r_wr_ptr - AW'(1) - rd_idx_i;
  // Until the first entry is recorded, the seeded entry 0 (reset state code)
  // is shown as the newest code so hist_o reflects the FSM's reset state.
  assign w_hist_base = (r_cnt == '0) ? r_wr_ptr : r_wr_ptr - AW'(1);

  always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
    if (!st_rst_ni) begin
      r_st <= TR_RUN;
      r_pcnt <= '0;
    end else begin
      r_st <= w_st_nxt;
      r_pcnt <= w_pcnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_pcnt_nxt = r_pcnt;
    case (r_st)
      TR_RUN: begin
        if (arm_i) w_st_nxt = TR_ARMED;
      end
      TR_ARMED: begin
        if (w_we && w_trig) begin
          if (post_i == '0) begin
            w_st_nxt = TR_FROZEN;
          end else begin
            w_st_nxt   = TR_POST;
            w_pcnt_nxt = post_i;
          end
        end
      end
      TR_POST: begin
        if (w_we) begin
          w_pcnt_nxt = r_pcnt - AW'(1);
          if (r_pcnt == AW'(1)) w_st_nxt = TR_FROZEN;
        end
      end
      default: ;
    endcase
    if (clr_i) begin
      w_st_nxt   = TR_RUN;
      w_pcnt_nxt = '0;
    end
  end

  always_ff @(posedge st_clk_i or negedge st_rst_ni) begin
    if (!st_rst_ni) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_dw_cnt <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_dw_cnt <= '0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_dw_cnt <= '0;
        if (r_cnt == c_depth) r_ovf <= 1'b1;
        else                  r_cnt <= r_cnt + 1'b1;
      end else if ((r_st != TR_FROZEN) && !(&r_dw_cnt)) begin
        r_dw_cnt <= r_dw_cnt + 1'b1;
      end
    end
  end

  qnet_trace_mem #(
    .ST_W   (ST_W),
    .DW_W   (DW_W),
    .DEPTH  (DEPTH),
    .HIST_N (HIST_N),
    .EMPTY  (c_empty)
  ) u_mem (
    .i_clk       (st_clk_i),
    .i_rst_n     (st_rst_ni),
    .i_clr       (clr_i),
    .i_we        (w_we),
    .i_wa        (r_wr_ptr),
    .i_wcode     (nxt_st_i),
    .i_wdw       (w_dwell),
    .i_ra        (w_rd_addr),
    .i_hist_base (w_hist_base),
    .o_rd_code   (rd_code_o),
    .o_rd_dw     (rd_dw_o),
    .o_hist      (hist_o)
  );

  assign trace_st_o = r_st;
  assign cnt_o      = r_cnt;
  assign ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_qnet_st_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_qnet_st_trace
// Purpose  : Directed self-checking bench for qnet_st_trace at default
//            parameters (ST_W=6, DEPTH=16, HIST_N=5, DW_W=16).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_qnet_st_trace;
  import qnet_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  cur_st, nxt_st, trig_code;
  logic        clr, arm;
  logic [3:0]  post, rd_idx;
  logic [5:0]  rd_code;
  logic [15:0] rd_dw;
  logic [29:0] hist;
  logic [1:0]  trace_st;
  logic [4:0]  cnt;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [29:0] c_hist_rst = {6'd0, 6'd62, 6'd62, 6'd62, 6'd62};

  always #5 clk = ~clk;

  qnet_st_trace dut (
    .st_clk_i    (clk),
    .st_rst_ni   (rst_n),
    .cur_st_i    (cur_st),
    .nxt_st_i    (nxt_st),
    .clr_i       (clr),
    .arm_i       (arm),
    .trig_code_i (trig_code),
    .post_i      (post),
    .rd_idx_i    (rd_idx),
    .rd_code_o   (rd_code),
    .rd_dw_o     (rd_dw),
    .hist_o      (hist),
    .trace_st_o  (trace_st),
    .cnt_o       (cnt),
    .ovf_o       (ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the current state hold-1 cycles, then present one change cycle.
  task automatic go(input logic [5:0] code, input int hold);
    nxt_st = cur_st;
    tick(hold - 1);
    nxt_st = code;
    tick(1);
    cur_st = code;
  endtask

  task automatic rd(input string tag, input logic [3:0] idx,
                    input logic [5:0] exp_code, input logic [15:0] exp_dw);
    rd_idx = idx;
    tick(1);
    chk({tag, "_code"}, 64'(rd_code), 64'(exp_code));
    chk({tag, "_dw"},   64'(rd_dw),   64'(exp_dw));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cur_st = '0; nxt_st = '0; clr = 1'b0; arm = 1'b0;
    trig_code = '0; post = '0; rd_idx = '0;
    tick(2);
    chk("rst_cnt",  64'(cnt), 64'd0);
    chk("rst_ovf",  64'(ovf), 64'd0);
    chk("rst_st",   64'(trace_st), 64'd0);
    chk("rst_rdc",  64'(rd_code), 64'd0);
    chk("rst_rdd",  64'(rd_dw), 64'd0);
    chk("rst_hist", 64'(hist), 64'(c_hist_rst));
    rst_n = 1'b1;

    // Basic recording: 0 -> 2 -> 5 -> 7, three cycles each.
    go(6'd2, 3); go(6'd5, 3); go(6'd7, 3);
    nxt_st = cur_st;
    chk("t1_cnt", 64'(cnt), 64'd3);
    chk("t1_hist", 64'(hist), 64'({6'd7, 6'd5, 6'd2, 6'd62, 6'd62}));
    rd("t1_r0", 4'd0, 6'd7, 16'd3);
    rd("t1_r1", 4'd1, 6'd5, 16'd3);
    rd("t1_r2", 4'd2, 6'd2, 16'd3);
    rd("t1_r3", 4'd3, 6'd62, 16'd0);

    // Wrap and overflow: 20 transitions 10..29, two cycles each.
    do_clr();
    chk("t2_clr_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 20; i++) go(6'(10 + i), 2);
    nxt_st = cur_st;
    chk("t2_cnt", 64'(cnt), 64'd16);
    chk("t2_ovf", 64'(ovf), 64'd1);
    chk("t2_hist", 64'(hist), 64'({6'd29, 6'd28, 6'd27, 6'd26, 6'd25}));
    rd("t2_r15", 4'd15, 6'd14, 16'd2);
    rd("t2_r0",  4'd0,  6'd29, 16'd2);

    // Trigger on 12 with two post-trigger entries.
    do_clr();
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("t3_armed", 64'(trace_st), 64'd1);
    trig_code = 6'd12; post = 4'd2;
    go(6'd3, 2); go(6'd12, 2);
    chk("t3_post", 64'(trace_st), 64'd2);
    go(6'd13, 2);
    chk("t3_post2", 64'(trace_st), 64'd2);
    go(6'd14, 2);
    chk("t3_frozen", 64'(trace_st), 64'd3);
    go(6'd15, 2);
    nxt_st = cur_st;
    chk("t3_cnt", 64'(cnt), 64'd4);
    chk("t3_hist", 64'(hist), 64'({6'd14, 6'd13, 6'd12, 6'd3, 6'd62}));
    rd("t3_r0", 4'd0, 6'd14, 16'd2);
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("t3_arm_ign", 64'(trace_st), 64'd3);

    // post_i = 0: freeze on the trigger write itself.
    do_clr();
    trig_code = qnet_cmd_code(ST_ERROR); post = 4'd0;
    arm = 1'b1; tick(1); arm = 1'b0;
    go(qnet_cmd_code(ST_ERROR), 2);
    chk("t4_frozen", 64'(trace_st), 64'd3);
    go(6'd5, 2); go(6'd6, 4);
    nxt_st = cur_st;
    chk("t4_cnt", 64'(cnt), 64'd1);
    rd("t4_r0", 4'd0, 6'd63, 16'd3);

    // clr coincident with chg and arm while in POST, with ovf set.
    do_clr();
    trig_code = qnet_cmd_code(NET_START_CORE_P); post = 4'd3;
    arm = 1'b1; tick(1); arm = 1'b0;
    for (int i = 0; i < 17; i++) go(6'(30 + i), 1);
    go(6'd20, 1);
    nxt_st = cur_st;
    chk("t5_ovf_pre", 64'(ovf), 64'd1);
    chk("t5_post", 64'(trace_st), 64'd2);
    clr = 1'b1; arm = 1'b1; nxt_st = 6'd21;
    tick(1);
    clr = 1'b0; arm = 1'b0; cur_st = 6'd21; nxt_st = 6'd21;
    chk("t5_st", 64'(trace_st), 64'd0);
    chk("t5_cnt", 64'(cnt), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_hist", 64'(hist), 64'(c_hist_rst));

    // Dwell saturation: hold one state well beyond 2^16 cycles.
    do_clr();
    go(6'd9, 66000);
    go(6'd10, 3);
    nxt_st = cur_st;
    rd("t6_r1", 4'd1, 6'd9, 16'd65535);
    rd("t6_r0", 4'd0, 6'd10, 16'd3);
    chk("t6_cnt", 64'(cnt), 64'd2);

    // Async reset mid-trace, checked without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt",  64'(cnt), 64'd0);
    chk("ar_st",   64'(trace_st), 64'd0);
    chk("ar_rdc",  64'(rd_code), 64'd0);
    chk("ar_rdd",  64'(rd_dw), 64'd0);
    chk("ar_hist", 64'(hist), 64'(c_hist_rst));
    chk("ar_ovf",  64'(ovf), 64'd0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
